ps2_mouse_tracker: RTL
======================

Name: ps2_mouse_tracker

Overview:
- Upstream stage of the mouse display path.
- Consumes the byte stream from the PS/2 receiver and assembles standard 3-byte mouse packets.
- Accumulates a clamped cursor position from each packet.
- Exposes status, x and y as a small combinational read-only register file via addr/data. The display stage polls this register file in round-robin.

Parameters:
- X_MAX, 159: largest legal cursor x (cursor grid units).
- Y_MAX, 119: largest legal cursor y.
- X_INIT, 80: x after reset.
- Y_INIT, 60: y after reset.
- TIMEOUT, 100000: max clk cycles between bytes of one packet before the partial packet is abandoned. 2 ms at 50 MHz.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  byte from PS/2 receiver, valid when rx_valid=1.
- rx_valid  input  1  one-cycle strobe, one byte per strobe.
- rx_err  input  1  one-cycle strobe, parity/framing error on the current byte.
- addr  input  2  register select.
- data  output  8  register read data, combinational from addr.
- pkt_strobe  output  1  one-cycle pulse in the cycle after a packet commits.

Behaviour:
- Reset (async, rst=1):
  - status=8'h08, x=X_INIT, y=Y_INIT, pkt_cnt=0, state=WAIT_B0, timer=0, pkt_strobe=0.
  - Reset mid-packet discards all partial bytes.
- Read map, combinational, no latency:
  - addr 0: status (byte0 of the last committed packet).
  - addr 1: x[7:0].
  - addr 2: y[7:0].
  - addr 3: pkt_cnt, an 8-bit committed-packet counter that wraps 255 -> 0.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2.
  - WAIT_B0:
    - On rx_valid with rx_data[3]=1: latch b0, go to WAIT_B1.
    - On rx_valid with rx_data[3]=0: drop the byte, stay (resync).
  - WAIT_B1: on rx_valid, latch b1, go to WAIT_B2.
  - WAIT_B2: on rx_valid, latch b2, commit (below), go to WAIT_B0.
- Error and timeout handling:
  - rx_err in any state forces WAIT_B0 with no commit. It has priority over rx_valid in the same cycle.
  - Timer clears on every rx_valid. It counts while in WAIT_B1 or WAIT_B2.
  - When the timer reaches TIMEOUT-1 without a byte, go to WAIT_B0 and drop the partial packet. The timer is held at 0 in WAIT_B0.
- Commit (same clock edge as byte 2 acceptance):
  - dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], rx_data}.
  - nx = x + dx and ny = y - dy, computed in signed 11-bit. Y is inverted because PS/2 +dy means up and screen y grows downward.
  - Clamp: below 0 -> 0; above X_MAX/Y_MAX -> max.
  - If b0[6] (x overflow) is set, x is unchanged. If b0[7] (y overflow) is set, y is unchanged.
  - status <= b0 even when overflow bits are set.
  - status, x, y and pkt_cnt update in the same edge, so a reader never sees a mixed packet.
  - pkt_strobe is high for exactly the next cycle.
- Bytes arriving in consecutive cycles are accepted; there is no back-pressure and every rx_valid is consumed.
- X_MAX and Y_MAX are each <= 255; positions are held in 8 bits.

Decomposition:
- Shared package mouse_pkg:
  - Register address constants: MREG_STATUS=0, MREG_X=1, MREG_Y=2, MREG_CNT=3.
  - Packet state enum.
  - Status bit indices: BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7.
- Sub-module: mouse_axis_accum (one instance per axis). Parameters MAX and INIT; inputs 9-bit delta and ovf; performs signed add, clamp and overflow hold. The y instance is fed a negated delta.

Test Plan:
- Reset value check: assert rst -> reads give addr0=8'h08, addr1=80, addr2=60, addr3=0.
- Basic move and button: send 8'h09,8'h05,8'h03 -> x=85, y=57, status=8'h09, pkt_cnt=1, pkt_strobe pulses once.
- Negative clamp: from reset send 8'h18,8'h9C,8'h00 (dx=-100) -> x=0. Then send 8'h28,8'h00,8'h9C (dy=-100) -> y clamps to 119.
- Overflow hold: send 8'h48,8'h7F,8'h02 -> x unchanged at 80, y=58, status=8'h48.
- Resync: send 8'h00 then 8'h08,8'h01,8'h01 -> the first byte is dropped; x=81, y=59, pkt_cnt=1.
- Timeout/error: send 8'h08,8'h10, idle TIMEOUT cycles, then 8'h08,8'h02,8'h00 -> x=82 (stale 8'h10 discarded). Repeat with rx_err during byte 1 -> no commit, pkt_cnt unchanged.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: register map, packet
// assembly states, status-byte bit positions and small decode helpers.
package mouse_pkg;

    localparam logic [1:0] MREG_STATUS = 2'd0;
    localparam logic [1:0] MREG_X      = 2'd1;
    localparam logic [1:0] MREG_Y      = 2'd2;
    localparam logic [1:0] MREG_CNT    = 2'd3;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } pkt_state_e;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam logic [7:0] STATUS_RESET = 8'h08;

    // A valid first byte always carries the sync bit.
    function automatic logic is_sync(input logic [7:0] b);
        return b[SYNC];
    endfunction

    // Widen a PS/2 9-bit two's-complement delta to 10 bits so its negation fits.
    function automatic logic [9:0] sext_delta(input logic sign, input logic [7:0] mag);
        return {sign, sign, mag};
    endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: adds a signed delta to the held position, clamps it to
// [0, MAX], and leaves the position untouched when the packet flags overflow.
module mouse_axis_accum #(
    parameter int MAX  = 159,
    parameter int INIT = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic signed [9:0] delta_i,
    input  logic              ovf_i,
    output logic [7:0]        pos_o
);

    localparam logic [7:0] MAX_V  = 8'(MAX);
    localparam logic [7:0] INIT_V = 8'(INIT);

    logic [7:0]         pos_q;
    logic [7:0]         pos_d;
    logic signed [10:0] sum_s;

    // Next position: signed sum, then clamp to the legal window.
    always_comb begin
        sum_s = $signed({3'b000, pos_q}) + $signed({delta_i[9], delta_i});
        pos_d = pos_q;
        if (en_i && !ovf_i) begin
            if (sum_s < 11'sd0) begin
                pos_d = 8'd0;
            end else if (sum_s > $signed({3'b000, MAX_V})) begin
                pos_d = MAX_V;
            end else begin
                pos_d = sum_s[7:0];
            end
        end else begin
            pos_d = pos_q;
        end
    end

    // Position register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= INIT_V;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream, tracks a
// clamped cursor position and exposes status/x/y/count as a read-only register file.
module ps2_mouse_tracker
    import mouse_pkg::*;
#(
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119,
    parameter int X_INIT  = 80,
    parameter int Y_INIT  = 60,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    input  logic [1:0] addr,
    output logic [7:0] data,
    output logic       pkt_strobe
);

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    pkt_state_e        state_q;
    logic [7:0]        b0_q;
    logic [7:0]        b1_q;
    logic [TW-1:0]     timer_q;
    logic [7:0]        status_q;
    logic [7:0]        cnt_q;
    logic              strobe_q;

    logic              commit_s;
    logic signed [9:0] dx_s;
    logic signed [9:0] dy_neg_s;
    logic [7:0]        x_s;
    logic [7:0]        y_s;

    // Third byte accepted this cycle; the error strobe vetoes it.
    always_comb begin
        commit_s = (state_q == WAIT_B2) && rx_valid && !rx_err;
        dx_s     = sext_delta(b0_q[XSIGN], b1_q);
        dy_neg_s = 10'sd0 - $signed(sext_delta(b0_q[YSIGN], rx_data));
    end

    mouse_axis_accum #(
        .MAX  (X_MAX),
        .INIT (X_INIT)
    ) u_x_axis (
        .clk     (clk),
        .rst     (rst),
        .en_i    (commit_s),
        .delta_i (dx_s),
        .ovf_i   (b0_q[XOVF]),
        .pos_o   (x_s)
    );

    // Screen y grows downward while PS/2 +dy means up, hence the negated delta.
    mouse_axis_accum #(
        .MAX  (Y_MAX),
        .INIT (Y_INIT)
    ) u_y_axis (
        .clk     (clk),
        .rst     (rst),
        .en_i    (commit_s),
        .delta_i (dy_neg_s),
        .ovf_i   (b0_q[YOVF]),
        .pos_o   (y_s)
    );

    // Packet assembly FSM with inter-byte timeout, status/count commit and strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_B0;
            b0_q     <= 8'd0;
            b1_q     <= 8'd0;
            timer_q  <= '0;
            status_q <= STATUS_RESET;
            cnt_q    <= 8'd0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= commit_s;
            if (rx_err) begin
                state_q <= WAIT_B0;
                timer_q <= '0;
            end else if (rx_valid) begin
                timer_q <= '0;
                case (state_q)
                    WAIT_B0: begin
                        if (is_sync(rx_data)) begin
                            b0_q    <= rx_data;
                            state_q <= WAIT_B1;
                        end else begin
                            state_q <= WAIT_B0;
                        end
                    end
                    WAIT_B1: begin
                        b1_q    <= rx_data;
                        state_q <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        status_q <= b0_q;
                        cnt_q    <= cnt_q + 8'd1;
                        state_q  <= WAIT_B0;
                    end
                    default: begin
                        state_q <= WAIT_B0;
                    end
                endcase
            end else if (state_q == WAIT_B0) begin
                timer_q <= '0;
            end else if (timer_q == TMO_LAST) begin
                state_q <= WAIT_B0;
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    // Read mux; the display stage polls this without latency.
    always_comb begin
        data = 8'd0;
        case (addr)
            MREG_STATUS: data = status_q;
            MREG_X:      data = x_s;
            MREG_Y:      data = y_s;
            MREG_CNT:    data = cnt_q;
            default:     data = 8'd0;
        endcase
    end

    assign pkt_strobe = strobe_q;

endmodule
